// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle radix-2 restoring divider for the HI/LO unit. It serves DIV
// (signed) and DIVU (unsigned). The divider works on operand magnitudes and
// applies a sign correction in the FINISH cycle.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   Op_div     start a signed divide (sampled in IDLE only, wins over Op_divu)
//   Op_divu    start an unsigned divide (sampled in IDLE only)
//   Abort      synchronous flush of any in-flight operation
//   Dividend   numerator, sampled on the start edge
//   Divisor    denominator, sampled on the start edge
//   Quotient   registered quotient (LO)
//   Remainder  registered remainder (HI)
//   Stall      high while an operation is in flight
//   Done       one-cycle pulse, results valid in the same cycle
//
// Optional build macro
//   SEQ_DIVIDER_EARLY_OUT_EN  when defined, an operation with a non-zero
//                             divisor and |Dividend| < |Divisor| goes straight
//                             from IDLE to FINISH and skips the BUSY iterations.
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Op_div,
    input  logic             Op_divu,
    input  logic             Abort,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Stall,
    output logic             Done
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    // Two's-complement negation with wrap-around. |0x80000000| stays
    // 0x80000000, which is what makes the signed-overflow case come out right.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return (~x) + W_ONE;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;        // dividend magnitude, becomes quotient
    logic [WIDTH-1:0] dvs_q, dvs_d;        // divisor magnitude
    logic [WIDTH-1:0] raw_q, raw_d;        // raw dividend for divide-by-zero
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             stall_q, stall_d;
    logic             done_q, done_d;

    logic             start_s;
    logic             is_signed_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH:0]   partial_s;
    logic [WIDTH:0]   diff_s;

    // Start decode, operand magnitudes and one restoring-division step.
    always_comb begin
        start_s     = (Op_div | Op_divu) & ~Abort;
        is_signed_s = Op_div;
        a_mag_s     = (is_signed_s & Dividend[WIDTH-1]) ? negate(Dividend) : Dividend;
        b_mag_s     = (is_signed_s & Divisor[WIDTH-1])  ? negate(Divisor)  : Divisor;
        // rem_q[WIDTH-1] is always 0 before the last shift, so the 33-bit
        // partial never loses information.
        partial_s   = {rem_q, dvd_q[WIDTH-1]};
        diff_s      = partial_s - {1'b0, dvs_q};
    end

    // Next-state and datapath update for the IDLE / BUSY / FINISH sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        raw_d     = raw_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    neg_quo_d = is_signed_s & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
                    neg_rem_d = is_signed_s & Dividend[WIDTH-1];
                    dvd_d     = a_mag_s;
                    dvs_d     = b_mag_s;
                    rem_d     = W_ZERO;
                    raw_d     = Dividend;
                    dbz_d     = (Divisor == W_ZERO);
                    cnt_d     = CNT_LAST;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
                    // Quotient is 0; the remainder magnitude is |Dividend| and
                    // the normal sign correction restores the raw dividend.
                    if ((Divisor != W_ZERO) && (a_mag_s < b_mag_s)) begin
                        rem_d   = a_mag_s;
                        dvd_d   = W_ZERO;
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_BUSY;
                    end
`else
                    state_d   = ST_BUSY;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                end else begin
                    // Negative difference (bit WIDTH set) means restore.
                    rem_d = diff_s[WIDTH] ? partial_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], ~diff_s[WIDTH]};
                    if (cnt_q == CNT_ZERO) begin
                        state_d = ST_FINISH;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            ST_FINISH: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                end else begin
                    quo_out_d = dbz_q ? W_ONES : (neg_quo_q ? negate(dvd_q) : dvd_q);
                    rem_out_d = dbz_q ? raw_q  : (neg_rem_q ? negate(rem_q) : rem_q);
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        stall_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            rem_q     <= W_ZERO;
            dvd_q     <= W_ZERO;
            dvs_q     <= W_ZERO;
            raw_q     <= W_ZERO;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            quo_out_q <= W_ZERO;
            rem_out_q <= W_ZERO;
            stall_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            raw_q     <= raw_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            stall_q   <= stall_d;
            done_q    <= done_d;
        end
    end

    assign Quotient  = quo_out_q;
    assign Remainder = rem_out_q;
    assign Stall     = stall_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Self-checking bench for seq_divider: a table of directed vectors, a few
// hand-written sequences for abort/reset/ignored-start corners, and random
// operations checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        Op_div = 1'b0;
    logic        Op_divu = 1'b0;
    logic        Abort = 1'b0;
    logic [31:0] Dividend = 32'd0;
    logic [31:0] Divisor = 32'd0;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        Stall;
    logic        Done;

    seq_divider #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .Op_div    (Op_div),
        .Op_divu   (Op_divu),
        .Abort     (Abort),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Stall     (Stall),
        .Done      (Done)
    );

    always #5 clock = ~clock;

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic (truncating division, remainder
    // follows the dividend) plus the divide-by-zero rule.
    function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb, mq, mr, ma, mb;
        if (b == 32'd0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            lat = 33;
            return;
        end
        sa  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        mq  = sa / sb;
        mr  = sa % sb;
        q   = mq[31:0];
        r   = mr[31:0];
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        lat = (ma < mb) ? EO_LAT : 33;
    endfunction

    // Issue one operation and wait (bounded) for Done. lat = number of edges
    // after the start edge at which Done is first seen, 0 if it never came.
    task automatic run_op(input bit sd, input bit su, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output int lat,
                          output bit stall_ok, output bit hold_ok);
        logic [31:0] pq, pr;
        @(negedge clock);
        pq = Quotient;
        pr = Remainder;
        Op_div = sd; Op_divu = su; Dividend = a; Divisor = b;
        @(posedge clock);
        #1;
        Op_div = 1'b0; Op_divu = 1'b0;
        Dividend = $urandom; Divisor = $urandom;
        stall_ok = (Stall === 1'b1);
        hold_ok  = 1'b1;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock);
            #1;
            if (Done === 1'b1) begin
                lat = n;
                if (Stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (Stall !== 1'b1) stall_ok = 1'b0;
            if (Quotient !== pq || Remainder !== pr) hold_ok = 1'b0;
        end
        q = Quotient;
        r = Remainder;
    endtask

    typedef struct {
        bit          sd;
        bit          su;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] gq, gr, eq, er, pq, pr;
    int          glat, elat;
    bit          st_ok, hd_ok, seen;

    initial begin
        tbl.push_back('{1'b0, 1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          33,     "divu_100_7"});
        tbl.push_back('{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33,     "div_m7_2"});
        tbl.push_back('{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33,     "div_7_m2"});
        tbl.push_back('{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33,     "div_ovf"});
        tbl.push_back('{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  EO_LAT, "divu_ovf_ops"});
        tbl.push_back('{1'b1, 1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  33,     "div_by0"});
        tbl.push_back('{1'b0, 1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  33,     "divu_by0"});
        tbl.push_back('{1'b1, 1'b0, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF0,  33,     "div_neg_by0"});
        tbl.push_back('{1'b0, 1'b1, 32'd5,          32'd9,          32'd0,          32'd5,          EO_LAT, "divu_5_9"});
        tbl.push_back('{1'b1, 1'b0, 32'hFFFF_FFFB,  32'd9,          32'd0,          32'hFFFF_FFFB,  EO_LAT, "div_m5_9"});
        tbl.push_back('{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33,     "both_ops_signed"});
        tbl.push_back('{1'b0, 1'b1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33,     "divu_max_1"});
        tbl.push_back('{1'b0, 1'b1, 32'd9,          32'd3,          32'd3,          32'd0,          33,     "divu_9_3"});

        // Asynchronous reset state.
        #1;
        check("rst_quotient", Quotient, 32'd0);
        check("rst_remainder", Remainder, 32'd0);
        check1("rst_stall", Stall, 1'b0);
        check1("rst_done", Done, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Directed table; consecutive entries also exercise back-to-back issue.
        foreach (tbl[i]) begin
            run_op(tbl[i].sd, tbl[i].su, tbl[i].a, tbl[i].b, gq, gr, glat, st_ok, hd_ok);
            check({tbl[i].name, "_q"}, gq, tbl[i].q);
            check({tbl[i].name, "_r"}, gr, tbl[i].r);
            check({tbl[i].name, "_lat"}, 32'(glat), 32'(tbl[i].lat));
            check1({tbl[i].name, "_stall"}, st_ok, 1'b1);
            check1({tbl[i].name, "_hold"}, hd_ok, 1'b1);
        end

        // Abort at edge k+10: no Done, outputs unchanged.
        pq = Quotient; pr = Remainder;
        @(negedge clock);
        Op_divu = 1'b1; Dividend = 32'd1000; Divisor = 32'd3;
        @(posedge clock);
        #1 Op_divu = 1'b0;
        repeat (9) @(posedge clock);
        #1 Abort = 1'b1;
        @(posedge clock);
        #1 Abort = 1'b0;
        check1("abort_stall", Stall, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1 if (Done === 1'b1) seen = 1'b1;
        end
        check1("abort_no_done", seen, 1'b0);
        check("abort_q_hold", Quotient, pq);
        check("abort_r_hold", Remainder, pr);

        // Reset at edge k+10: outputs clear immediately, no Done afterwards.
        @(negedge clock);
        Op_divu = 1'b1; Dividend = 32'd1000; Divisor = 32'd3;
        @(posedge clock);
        #1 Op_divu = 1'b0;
        repeat (9) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("midrst_q", Quotient, 32'd0);
        check("midrst_r", Remainder, 32'd0);
        check1("midrst_stall", Stall, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1 if (Done === 1'b1) seen = 1'b1;
        end
        check1("midrst_no_done", seen, 1'b0);
        run_op(1'b0, 1'b1, 32'd9, 32'd3, gq, gr, glat, st_ok, hd_ok);
        check("after_rst_q", gq, 32'd3);
        check("after_rst_r", gr, 32'd0);
        check("after_rst_lat", 32'(glat), 32'd33);

        // Abort in IDLE blocks a same-cycle start.
        @(negedge clock);
        Op_div = 1'b1; Abort = 1'b1; Dividend = 32'd50; Divisor = 32'd5;
        @(posedge clock);
        #1 Op_div = 1'b0; Abort = 1'b0;
        check1("idle_abort_stall", Stall, 1'b0);

        // Op_divu during BUSY is ignored and not queued.
        @(negedge clock);
        Op_div = 1'b1; Dividend = 32'hFFFF_FFF9; Divisor = 32'd2;
        @(posedge clock);
        #1 Op_div = 1'b0;
        repeat (4) @(posedge clock);
        #1 Op_divu = 1'b1; Dividend = 32'd50; Divisor = 32'd5;
        @(posedge clock);
        #1 Op_divu = 1'b0;
        glat = 0;
        for (int n = 6; n <= 60; n++) begin
            @(posedge clock);
            #1;
            if (Done === 1'b1) begin
                glat = n;
                break;
            end
        end
        check("ignored_lat", 32'(glat), 32'd33);
        check("ignored_q", Quotient, 32'hFFFF_FFFD);
        check("ignored_r", Remainder, 32'hFFFF_FFFF);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1 if (Stall === 1'b1 || Done === 1'b1) seen = 1'b1;
        end
        check1("ignored_not_queued", seen, 1'b0);

        // Random operations against the reference model.
        for (int i = 0; i < 200; i++) begin
            bit          sd, su;
            logic [31:0] a, b;
            sd = 1'($urandom_range(0, 1));
            su = sd ? 1'($urandom_range(0, 1)) : 1'b1;
            a  = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 40));
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'd0 - 32'($urandom_range(1, 15));
                3:       b = a >> $urandom_range(0, 8);
                default: b = $urandom;
            endcase
            ref_div(sd, a, b, eq, er, elat);
            run_op(sd, su, a, b, gq, gr, glat, st_ok, hd_ok);
            check("rand_q", gq, eq);
            check("rand_r", gr, er);
            check("rand_lat", 32'(glat), 32'(elat));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle 32-bit integer divider for the MIPS32 core's HI/LO unit. Adds beside the combinational adder and produces quotient and remainder by repeated subtraction.
- Radix-2 restoring algorithm on operand magnitudes, with a final sign-correction step.
- Serves both DIV (signed) and DIVU (unsigned).
- The pipeline stalls on Stall and captures the result on Done.

Parameters:
- WIDTH, 32, operand and result width in bits. Only 32 is verified. The iteration counter is sized to represent WIDTH-1 down to 0.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Op_div  input  1  start signed divide. Sampled only in IDLE.
- Op_divu  input  1  start unsigned divide. Sampled only in IDLE. Op_div wins if both are asserted.
- Abort  input  1  synchronous flush. Kills any in-flight operation.
- Dividend  input  WIDTH  numerator. Sampled on the start edge only.
- Divisor  input  WIDTH  denominator. Sampled on the start edge only.
- Quotient  output  WIDTH  registered result (LO)
- Remainder  output  WIDTH  registered result (HI)
- Stall  output  1  high while an operation is in flight (state != IDLE)
- Done  output  1  one-cycle pulse; results are valid in the same cycle

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, Quotient=0, Remainder=0, Stall=0, Done=0, and all internal registers cleared. Asserting reset mid-operation discards the operation, and no Done is produced.
- States: IDLE, BUSY, FINISH.
- IDLE:
  - On an edge with Op_div|Op_divu=1 and Abort=0: latch the mode.
  - Latch |Dividend| and |Divisor|. Magnitudes apply in signed mode only; unsigned mode uses raw values.
  - Latch sign_q = Dividend[31]^Divisor[31] and sign_r = Dividend[31] (signed mode), or both 0 (unsigned mode).
  - Latch the raw Dividend for the divide-by-zero case.
  - Set counter=WIDTH-1 and go to BUSY.
- BUSY, each cycle:
  - Form partial remainder {rem[30:0], dvd[31]} and subtract the divisor magnitude using a 33-bit subtraction.
  - If the 33-bit result is non-negative: rem = difference and the quotient bit is 1.
  - Otherwise: rem is restored and the quotient bit is 0.
  - Shift the dividend/quotient register left by one.
  - At counter=0, go to FINISH; otherwise decrement the counter.
- FINISH:
  - Quotient = sign_q ? -q : q.
  - Remainder = sign_r ? -r : r.
  - Done=1 for this cycle. Next state is IDLE.
- Latency: start sampled at edge k; Done=1 in the cycle following edge k+33. Stall=1 from edge k+1 until FINISH is left; Stall=0 in IDLE.
- Quotient and Remainder hold their value until the next FINISH or reset. They do not change during BUSY.
- Op_div/Op_divu while Stall=1 are ignored and never queued.
- Abort=1 in BUSY or FINISH: next state is IDLE, Done stays 0, and the outputs keep their previous values. Abort in IDLE blocks a same-cycle start.
- Back-to-back: a start may be sampled in the first IDLE cycle after FINISH, giving a minimum issue interval of 34 cycles.
- Divide by zero: full latency, Quotient=0xFFFFFFFF and Remainder=raw Dividend, in both modes with no sign correction. The FINISH logic overrides the result using a latched div-by-zero flag.
- Signed overflow 0x80000000 / 0xFFFFFFFF: Quotient=0x80000000, Remainder=0. This falls out of the magnitude arithmetic with wrap-around negation and must not be trapped.
- Remainder sign always follows the dividend sign; quotient truncates toward zero.

Optional Feature:
- Macro: SEQ_DIVIDER_EARLY_OUT_EN.
- When defined: in IDLE, if the divisor is non-zero and |Dividend| < |Divisor| (unsigned compare of the magnitudes), go directly to FINISH, skipping BUSY. The result is Quotient=0 and Remainder=raw Dividend, and Done appears in the cycle after edge k+1.
- When not defined: every operation takes the full 33 edges. Divide-by-zero always takes full latency in both builds.

Test Plan:
- Op_divu, 100/7 -> Done exactly 33 edges after start; Quotient=14, Remainder=2; Stall high for the 33 cycles before Done deasserts.
- Op_div, 0xFFFFFFF9/2 (-7/2) -> Quotient=0xFFFFFFFD (-3), Remainder=0xFFFFFFFF (-1). Then 7/0xFFFFFFFE -> Quotient=0xFFFFFFFD, Remainder=1.
- Op_div, 0x80000000/0xFFFFFFFF -> Quotient=0x80000000, Remainder=0. Op_divu with the same operands -> Quotient=0, Remainder=0x80000000.
- Divisor=0 with Dividend=0x12345678, both modes -> Quotient=0xFFFFFFFF, Remainder=0x12345678, full latency.
- Start 1000/3, assert Abort at edge k+10 -> no Done, Quotient/Remainder unchanged. Repeat with reset low at k+10 -> outputs 0 immediately. Then issue 9/3 -> Quotient=3, Remainder=0. A new Op_divu during BUSY is ignored.
- SEQ_DIVIDER_EARLY_OUT_EN defined, Op_divu 5/9 -> Done one cycle after FINISH entry (edge k+1), Quotient=0, Remainder=5. Not defined -> same result at edge k+33.
